pzc_event_capture: RTL and testbench
====================================

Name: pzc_event_capture

Overview:
- Downstream consumer of the PZC output (pzc_out) of the FPGA simulator top level.
- Arms on HPS command and stores PRE pre-trigger samples in a circular RAM.
- Triggers when the PZC sample strictly exceeds a programmable threshold, stores POST post-trigger samples, then freezes.
- Presents the captured window, the trigger bunch-crossing ID and a trigger count to the HPS through a request/valid read port.

Parameters:
- DATA_BITS, 29, width of signed pzc_out sample (CLIP_OUT_BITS+1+16).
- DEPTH_LOG, 6, log2 of circular buffer depth (64 entries).
- PRE_SAMPLES, 8, samples kept before trigger sample.
- POST_SAMPLES, 24, samples kept after trigger sample.
- BUNCH_POS, 3564, bunch-crossing counter modulus.
- Constraint: W = PRE_SAMPLES+POST_SAMPLES+1 <= 2**DEPTH_LOG.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- in_data  in  DATA_BITS  signed PZC sample, one per clock.
- bt_mask_in  in  1  bunch-train mask of the current sample.
- threshold  in  DATA_BITS  signed trigger threshold.
- arm  in  1  single-cycle start pulse.
- rd_req  in  1  request next captured word.
- rd_data  out  DATA_BITS  captured sample.
- rd_valid  out  1  rd_data valid, one cycle.
- busy  out  1  high in FILL, ARMED, POST.
- done  out  1  high in DONE (window ready/being read).
- trig_bcid  out  12  bunch ID at trigger sample.
- trig_count  out  16  triggers since reset, saturating at 65535.

Behaviour:
- Reset (rst=0, async): state IDLE; all pointers/counters 0; rd_data, rd_valid, busy, done, trig_bcid, trig_count = 0. RAM contents undefined.
- bcid: free-running 0..BUNCH_POS-1, wraps to 0 after BUNCH_POS-1.
- IDLE: no writes.
  - arm=1 -> FILL; pre_cnt=0.
  - arm in any other state is ignored.
- FILL: write in_data at wr_ptr each cycle, wr_ptr++ (mod 2**DEPTH_LOG). After PRE_SAMPLES writes -> ARMED. No triggering in FILL.
- ARMED: write every cycle.
  - Trigger when in_data > threshold (signed, strict) [and mask qualifier, see Optional Feature].
  - On the trigger cycle the sample is written; trig_addr = wr_ptr; trig_bcid = bcid; trig_count++ (saturating); post_cnt=0; -> POST.
  - With PRE_SAMPLES=0, FILL lasts zero cycles (arm -> ARMED directly).
- POST: write every cycle, post_cnt++. After POST_SAMPLES writes -> DONE. Threshold ignored. POST_SAMPLES=0 goes straight to DONE.
- DONE: writes stop; rd_ptr = trig_addr - PRE_SAMPLES (mod depth); rd_cnt=0.
  - rd_req=1 -> next cycle rd_data=RAM[rd_ptr], rd_valid=1; rd_ptr++, rd_cnt++.
  - Back-to-back rd_req gives one word per cycle.
  - After the W-th read is issued -> IDLE; done falls the cycle after the last rd_valid.
  - Read order: oldest pre-trigger sample first, trigger sample at index PRE_SAMPLES.
- rd_req outside DONE: ignored, rd_valid stays 0. rd_data holds its last value; it is 0 only after reset.
- Pointer wrap: wr_ptr wraps freely in ARMED; the window is always contiguous modulo depth.
- Reset mid-operation: capture aborted immediately; no partial window readable.
- Simultaneous arm and rd_req in DONE: arm ignored, read served.

Optional Feature:
- Macro PZC_CAP_BT_QUALIFY_EN.
- Defined: trigger additionally requires bt_mask_in=1 on the trigger sample.
- Undefined: bt_mask_in is unused and the trigger is threshold-only.

Test Plan (defaults; W=33):
- Reset: hold rst=0 with random inputs -> all outputs 0; release -> IDLE, busy=0.
- Ramp trigger: in_data=0,1,2,... per cycle, arm at sample 0, threshold=100 -> trigger on 101, trig_count=1; 33 back-to-back rd_req -> rd_data 93..125 in order, rd_valid 33 cycles, then done=0.
- Fill masking: threshold=0, constant in_data=50, arm -> no trigger for first 8 samples; trigger on 9th; readout 33×50; busy high 8+1+24 cycles.
- Wrap: threshold=1000, in_data=cycle index mod 512; arm; at cycle 200 force in_data=2000 -> readout 192..199, 2000, 201..224 (wr_ptr wrapped 3×).
- Protocol: rd_req in ARMED -> no rd_valid; arm during DONE -> ignored, window intact; trig_bcid equals bcid sampled at trigger (also checked across 3563->0 wrap).
- Abort: rst=0 at post_cnt=10 -> done=0, trig_count=0. With PZC_CAP_BT_QUALIFY_EN defined and bt_mask_in=0, in_data=5000 -> no trigger; bt_mask_in=1 -> trigger.

Source files
------------

// File: rtl/pzc_event_capture.sv
// Pre/post-trigger window capture of the PZC sample stream with a request/valid readout port.
// Optional macro PZC_CAP_BT_QUALIFY_EN: trigger additionally requires bt_mask_in=1.
module pzc_event_capture #(
    parameter int DATA_BITS    = 29,
    parameter int DEPTH_LOG    = 6,
    parameter int PRE_SAMPLES  = 8,
    parameter int POST_SAMPLES = 24,
    parameter int BUNCH_POS    = 3564
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_BITS-1:0] in_data,
    input  logic                        bt_mask_in,
    input  logic signed [DATA_BITS-1:0] threshold,
    input  logic                        arm,
    input  logic                        rd_req,
    output logic        [DATA_BITS-1:0] rd_data,
    output logic                        rd_valid,
    output logic                        busy,
    output logic                        done,
    output logic        [11:0]          trig_bcid,
    output logic        [15:0]          trig_count
);
    localparam int W     = PRE_SAMPLES + POST_SAMPLES + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(PRE_SAMPLES > 0 ? PRE_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0]     POST_LAST = CNT_W'(POST_SAMPLES > 0 ? POST_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0]     W_LAST    = CNT_W'(W - 1);
    localparam logic [DEPTH_LOG-1:0] PRE_PTR   = DEPTH_LOG'(PRE_SAMPLES);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE   = DEPTH_LOG'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG-1:0]   trig_addr_q, trig_addr_d;
    logic [CNT_W-1:0]       pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]       post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [11:0]            bcid_q, bcid_d;
    logic [11:0]            trig_bcid_q, trig_bcid_d;
    logic [15:0]            trig_count_q, trig_count_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_en;
    logic                   trig_hit;
    logic [DATA_BITS-1:0]   mem [DEPTH];

`ifdef PZC_CAP_BT_QUALIFY_EN
    assign trig_hit = (in_data > threshold) && bt_mask_in;
`else
    logic unused_bt_mask;
    assign unused_bt_mask = bt_mask_in;
    assign trig_hit       = (in_data > threshold);
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_addr_d  = trig_addr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        trig_bcid_d  = trig_bcid_q;
        trig_count_d = trig_count_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        wr_en        = 1'b0;
        bcid_d       = (bcid_q == 12'(BUNCH_POS - 1)) ? 12'd0 : bcid_q + 12'd1;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    pre_cnt_d = '0;
                    state_d   = (PRE_SAMPLES == 0) ? ARMED : FILL;
                end
            end
            FILL: begin
                wr_en     = 1'b1;
                wr_ptr_d  = wr_ptr_q + PTR_ONE;
                pre_cnt_d = pre_cnt_q + CNT_ONE;
                if (pre_cnt_q == PRE_LAST) state_d = ARMED;
            end
            ARMED: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (trig_hit) begin
                    trig_addr_d = wr_ptr_q;
                    trig_bcid_d = bcid_q;
                    if (trig_count_q != 16'hFFFF) trig_count_d = trig_count_q + 16'd1;
                    post_cnt_d = '0;
                    rd_cnt_d   = '0;
                    if (POST_SAMPLES == 0) begin
                        state_d  = DONE;
                        rd_ptr_d = wr_ptr_q - PRE_PTR;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                post_cnt_d = post_cnt_q + CNT_ONE;
                if (post_cnt_q == POST_LAST) begin
                    state_d  = DONE;
                    rd_ptr_d = trig_addr_q - PRE_PTR;
                    rd_cnt_d = '0;
                end
            end
            DONE: begin
                if (rd_req) begin
                    rd_data_d  = mem[rd_ptr_q];
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    rd_cnt_d   = rd_cnt_q + CNT_ONE;
                    if (rd_cnt_q == W_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FILL) || (state_d == ARMED) || (state_d == POST);
        // done stays up through the final rd_valid so the reader sees the last word inside the window
        done_d = (state_d == DONE) || rd_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_addr_q  <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            bcid_q       <= '0;
            trig_bcid_q  <= '0;
            trig_count_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_addr_q  <= trig_addr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            bcid_q       <= bcid_d;
            trig_bcid_q  <= trig_bcid_d;
            trig_count_q <= trig_count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_data;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trig_bcid  = trig_bcid_q;
    assign trig_count = trig_count_q;
endmodule

// File: tb/tb_pzc_event_capture.sv
// Scoreboard bench for pzc_event_capture: directed captures, readout order, bcid wrap, abort and mask qualifier.
module tb_pzc_event_capture;
    localparam int DB   = 29;
    localparam int PRE  = 8;
    localparam int POST = 24;
    localparam int W    = PRE + POST + 1;
    localparam int BP   = 3564;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DB-1:0] in_data;
    logic                 bt_mask_in;
    logic signed [DB-1:0] threshold;
    logic                 arm;
    logic                 rd_req;
    logic        [DB-1:0] rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;
    logic        [11:0]   trig_bcid;
    logic        [15:0]   trig_count;

    int          checks = 0;
    int          passes = 0;
    int          rd_valid_seen = 0;
    int          edges = 0;
    int          exp_bcid;
    int          busy_cycles;
    int          waited;
    int          base_seen;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] mon_exp;

    pzc_event_capture dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .bt_mask_in (bt_mask_in),
        .threshold  (threshold),
        .arm        (arm),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .trig_bcid  (trig_bcid),
        .trig_count (trig_count)
    );

    always #5 clk = ~clk;

    // Reference bunch counter: value during a cycle equals edges since reset release, modulo BP
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [DB-1:0] d, input logic m, input logic a, input logic r);
        @(negedge clk);
        in_data    = d;
        bt_mask_in = m;
        arm        = a;
        rd_req     = r;
    endtask

    // Monitor: every presented word is matched against the scoreboard queue
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            rd_valid_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic read_window(input logic arm_first);
        int base;
        base = rd_valid_seen;
        for (int i = 0; i < W; i++) applyStimulus('0, 1'b0, arm_first && (i == 0), 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_with_last_valid", 32'(done), 32'd1);
        checkOutput("rd_valid_last", 32'(rd_valid), 32'd1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_after_last", 32'(done), 32'd0);
        checkOutput("rd_valid_after_last", 32'(rd_valid), 32'd0);
        checkOutput("valid_count", 32'(rd_valid_seen - base), 32'(W));
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        in_data = '0; bt_mask_in = 1'b0; threshold = '0; arm = 1'b0; rd_req = 1'b0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            in_data    = DB'($urandom);
            threshold  = DB'($urandom);
            bt_mask_in = 1'($urandom);
            arm        = 1'($urandom);
            rd_req     = 1'($urandom);
        end
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_trig_bcid", 32'(trig_bcid), 32'd0);
        checkOutput("reset_trig_count", 32'(trig_count), 32'd0);
        @(negedge clk);
        in_data = '0; threshold = '0; bt_mask_in = 1'b0; arm = 1'b0; rd_req = 1'b0;
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);

        // Ramp trigger at 101, with stray rd_req while armed
        threshold = 29'sd100;
        for (int i = 0; i <= 125; i++) begin
            applyStimulus(DB'(i), 1'b0, i == 0, (i >= 20) && (i <= 22));
            if (i == 101) exp_bcid = edges % BP;
            if (i == 50) checkOutput("ramp_busy_armed", 32'(busy), 32'd1);
        end
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("ramp_done", 32'(done), 32'd1);
        checkOutput("ramp_busy", 32'(busy), 32'd0);
        checkOutput("ramp_trig_count", 32'(trig_count), 32'd1);
        checkOutput("ramp_trig_bcid", 32'(trig_bcid), 32'(exp_bcid));
        for (int v = 93; v <= 125; v++) exp_q.push_back(DB'(v));
        read_window(1'b0);

        // Fill masking: constant 50 over threshold 0
        threshold   = '0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(29'd50, 1'b0, i == 0, 1'b0);
            if (busy) busy_cycles++;
            if (i == 9) begin
                checkOutput("fill_no_early_trigger", 32'(trig_count), 32'd1);
                exp_bcid = edges % BP;
            end
            if (i == 10) checkOutput("fill_trigger_9th", 32'(trig_count), 32'd2);
        end
        checkOutput("fill_busy_cycles", 32'(busy_cycles), 32'(PRE + 1 + POST));
        checkOutput("fill_trig_bcid", 32'(trig_bcid), 32'(exp_bcid));
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("arm_in_done_done", 32'(done), 32'd1);
        checkOutput("arm_in_done_busy", 32'(busy), 32'd0);
        for (int v = 0; v < W; v++) exp_q.push_back(DB'(50));
        read_window(1'b1);

        // Wrap: index ramp mod 512 with a 2000 spike at index 200
        threshold = 29'sd1000;
        for (int i = 0; i <= 224; i++) begin
            applyStimulus((i == 200) ? DB'(2000) : DB'(i % 512), 1'b0, i == 0, 1'b0);
            if (i == 200) exp_bcid = edges % BP;
        end
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_done", 32'(done), 32'd1);
        checkOutput("wrap_trig_count", 32'(trig_count), 32'd3);
        checkOutput("wrap_trig_bcid", 32'(trig_bcid), 32'(exp_bcid));
        for (int v = 192; v <= 199; v++) exp_q.push_back(DB'(v));
        exp_q.push_back(DB'(2000));
        for (int v = 201; v <= 224; v++) exp_q.push_back(DB'(v));
        read_window(1'b0);

        // Trigger exactly on the last bunch before the bcid wrap
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0);
        waited = 0;
        while (((edges + 1) % BP) != (BP - 1) && waited < 4000) begin
            applyStimulus('0, 1'b0, 1'b0, 1'b0);
            waited++;
        end
        checkOutput("bcid_wait_bound", 32'(waited < 4000), 32'd1);
        applyStimulus(DB'(2000), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < POST; i++) applyStimulus(DB'(7), 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("bcidwrap_done", 32'(done), 32'd1);
        checkOutput("bcidwrap_trig_bcid", 32'(trig_bcid), 32'(BP - 1));
        checkOutput("bcidwrap_trig_count", 32'(trig_count), 32'd4);
        for (int v = 0; v < PRE; v++) exp_q.push_back('0);
        exp_q.push_back(DB'(2000));
        for (int v = 0; v < POST; v++) exp_q.push_back(DB'(7));
        read_window(1'b0);

        // Abort in POST at post_cnt=10
        threshold = '0;
        for (int i = 0; i <= 20; i++) applyStimulus(29'd50, 1'b0, i == 0, 1'b0);
        checkOutput("abort_pre_trig_count", 32'(trig_count), 32'd5);
        checkOutput("abort_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_trig_count", 32'(trig_count), 32'd0);
        checkOutput("abort_trig_bcid", 32'(trig_bcid), 32'd0);
        checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        base_seen = rd_valid_seen;
        for (int i = 0; i < 6; i++) applyStimulus('0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_no_readout", 32'(rd_valid_seen - base_seen), 32'd0);

        // Bunch-train mask qualifier
        threshold = 29'sd1000;
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < PRE; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0);
`ifdef PZC_CAP_BT_QUALIFY_EN
        applyStimulus(DB'(5000), 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("mask0_no_trigger", 32'(trig_count), 32'd0);
        checkOutput("mask0_still_busy", 32'(busy), 32'd1);
        applyStimulus(DB'(5000), 1'b1, 1'b0, 1'b0);
        for (int v = 0; v < 6; v++) exp_q.push_back('0);
        exp_q.push_back(DB'(5000));
        exp_q.push_back('0);
`else
        applyStimulus(DB'(5000), 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < PRE; v++) exp_q.push_back('0);
`endif
        exp_q.push_back(DB'(5000));
        for (int i = 0; i < POST; i++) applyStimulus(DB'(3), 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < POST; v++) exp_q.push_back(DB'(3));
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("mask_done", 32'(done), 32'd1);
        checkOutput("mask_trig_count", 32'(trig_count), 32'd1);
        read_window(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
